piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out stage directly upstream of the N-bit serial shift
//  register. Accepts N-bit words over a valid/ready handshake and drives them
//  one bit per clk onto the shift register's serial input (so -> si).
//  Supports gapless back-to-back words and reports per-word completion.
// PARAMETERS
//  N          4   data word width in bits (>=2)
//  LSB_FIRST  0   0: MSB shifted out first; 1: LSB shifted out first
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  asynchronous, active-low reset (0 = reset asserted)
//  din        in   N  parallel word to serialize
//  din_valid  in   1  din holds a valid word
//  din_ready  out  1  serializer can accept a word this cycle
//  so         out  1  serial data out; connects to downstream si
//  so_valid   out  1  so carries a data (or parity) bit this cycle
//  done       out  1  one-cycle pulse on the final bit of a word
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, shift reg=0, bit_cnt=0, so=0,
//   so_valid=0, done=0. din_ready=1 from the first cycle after release.
//  FSM: IDLE -> SHIFT on accept (din_valid && din_ready at posedge).
//   SHIFT -> SHIFT on last bit with a new accept (back-to-back reload);
//   SHIFT -> IDLE on last bit with no accept; SHIFT -> PARITY (PARITY_EN).
//  Accept loads din into the shift reg; bit_cnt=N-1. so/so_valid are
//   registered: the first bit appears the cycle after accept (latency 1).
//  Each SHIFT cycle: so = current head bit (MSB or LSB per LSB_FIRST),
//   shift reg shifts by 1, bit_cnt decrements; so_valid=1.
//  Last bit = SHIFT with bit_cnt==0 (no PARITY_EN) or PARITY state.
//  din_ready (comb) = IDLE || last bit; enables zero-bubble streaming.
//  done=1 exactly in the cycle the last bit of a word is on so.
//  In IDLE: so=0, so_valid=0, done=0. din is ignored unless accepted;
//   din_valid held high while busy is not consumed (din_ready=0).
//  Reset mid-word: word is discarded, outputs go to reset values
//   immediately; no partial word resumes.
//  Bit counter width $clog2(N); no wrap: reload or IDLE at 0.
// CONFIGURATION
//  Macro PISO_PARITY_EN:
//   Defined: after the N data bits, one extra cycle in PARITY state drives
//    so = even parity (XOR of the accepted word), so_valid=1, done=1 here.
//    The word occupies N+1 so cycles; din_ready asserts in PARITY.
//   Undefined: PARITY state and parity logic are absent; N cycles per word.
// STRUCTURE
//  Package piso_pkg: state enum {IDLE, SHIFT, PARITY}, localparam
//   CNT_W = $clog2(N) helper, parity function.
//  One sub-module: piso_bit_counter (load N-1, decrement, last flag).
//  Top holds FSM, shift register, handshake and output registers.
// TESTING (N=4 unless noted; bit sequence listed in so order)
//  1 Reset then din=4'b0110 valid 1 cycle -> so 0,1,1,0 over next 4 cycles,
//    so_valid=1 for those 4, done only on 4th, then so=0/so_valid=0.
//  2 Back-to-back 4'b1010 then 4'b0101, din_valid held -> 8 contiguous
//    bits 1,0,1,0,0,1,0,1; so_valid never drops; done on bits 4 and 8.
//  3 din_valid held high with 4'b1111 during a 4'b0000 word -> din_ready=0
//    for bits 1-3; 4'b1111 accepted only on bit 4; no corruption.
//  4 rst pulled low on bit 2 of 4'b1001 -> so=0, so_valid=0, done=0
//    immediately; after release din_ready=1 and next word serializes cleanly.
//  5 LSB_FIRST=1, din=4'b0001 -> so 1,0,0,0; done on 4th.
//  6 PISO_PARITY_EN, din=4'b0111 -> so 0,1,1,1,1 (parity bit 1), done on
//    5th; din=4'b0110 -> 0,1,1,0,0.
//  Bench chains so into the 4-bit shift register; after a word plus 4
//    flush cycles its so output must replay the same bit sequence.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Widest word the parity helper accepts; callers zero-extend into it.
    localparam int PAR_MAX_W = 64;

    // Bit-counter width for an N-bit word: it counts N-1 down to 0.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Even parity: 1 when the word holds an odd number of ones.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bits-remaining counter: loads N-1 on accept, decrements once per shifted bit.
// Latency: flags are combinational decodes of the registered count.
// Backpressure: none; load takes priority, holds at zero (no wrap).
// Ports: clk, rst (async active-low), i_load, i_dec -> o_last (count==0),
//        o_one (count==1, i.e. the next bit is the last data bit).
module piso_bit_counter #(
    parameter int N     = 4,
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_last,
    output logic o_one
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(N - 1);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == '0);
    assign o_one  = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding a serial shift register (so -> si).
// Latency: first bit on so one cycle after accept; N (N+1 with parity) cycles/word.
// Backpressure: din_ready only in IDLE or on the last bit, giving gapless reloads.
// Ports: clk, rst (async active-low), din[N-1:0]/din_valid/din_ready handshake,
//        so/so_valid serial output, done pulse on the final bit of each word.
// Option macro PISO_PARITY_EN: append one even-parity bit after the data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int N         = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         so,
    output logic         so_valid,
    output logic         done
);

    localparam int CNT_W = cnt_width(N);
`ifdef PISO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    state_t       r_state;
    logic [N-1:0] r_shreg;
    logic         r_so;
    logic         r_so_vld;
    logic         r_done;
`ifdef PISO_PARITY_EN
    logic         r_par;
`endif

    logic         w_cnt_last;
    logic         w_cnt_one;
    logic         w_last;
    logic         w_accept;
    logic         w_din_head;
    logic         w_sh_head;
    logic [N-1:0] w_din_shift;
    logic [N-1:0] w_sh_shift;

    // The head bit goes straight to so on load, so the register keeps only
    // the bits still to be sent.
    assign w_din_head  = LSB_FIRST ? din[0]     : din[N-1];
    assign w_din_shift = LSB_FIRST ? (din >> 1) : (din << 1);
    assign w_sh_head   = LSB_FIRST ? r_shreg[0] : r_shreg[N-1];
    assign w_sh_shift  = LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);

    assign w_last    = ((r_state == SHIFT) && w_cnt_last && !PAR_EN) || (r_state == PARITY);
    assign din_ready = (r_state == IDLE) || w_last;
    assign w_accept  = din_valid && din_ready;

    piso_bit_counter #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_dec  ((r_state == SHIFT) && !w_accept),
        .o_last (w_cnt_last),
        .o_one  (w_cnt_one)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_so     <= 1'b0;
            r_so_vld <= 1'b0;
            r_done   <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else if (w_accept) begin
            // New word (from IDLE or on the last bit of the previous word).
            r_state  <= SHIFT;
            r_so     <= w_din_head;
            r_shreg  <= w_din_shift;
            r_so_vld <= 1'b1;
            r_done   <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par    <= even_parity(PAR_MAX_W'(din));
`endif
        end else begin
            case (r_state)
                SHIFT: begin
                    if (!w_cnt_last) begin
                        r_so     <= w_sh_head;
                        r_shreg  <= w_sh_shift;
                        r_so_vld <= 1'b1;
                        // Count of 1 means the bit being loaded is the final data bit.
                        r_done   <= w_cnt_one && !PAR_EN;
                    end else begin
`ifdef PISO_PARITY_EN
                        r_state  <= PARITY;
                        r_so     <= r_par;
                        r_so_vld <= 1'b1;
                        r_done   <= 1'b1;
`else
                        r_state  <= IDLE;
                        r_so     <= 1'b0;
                        r_so_vld <= 1'b0;
                        r_done   <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_so     <= 1'b0;
                    r_so_vld <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign so       = r_so;
    assign so_valid = r_so_vld;
    assign done     = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first instance plus an LSB-first instance.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// The MSB-first output feeds a 4-bit shift register whose tail must replay the word.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int W = 5;
`else
    localparam int W = 4;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       so;
    logic       so_valid;
    logic       done;

    logic [3:0] l_din;
    logic       l_din_valid;
    logic       l_din_ready;
    logic       l_so;
    logic       l_so_valid;
    logic       l_done;

    logic [3:0] sr;

    int total = 0;
    int bad   = 0;

    piso_serializer #(.N(4), .LSB_FIRST(1'b0)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .so        (so),
        .so_valid  (so_valid),
        .done      (done)
    );

    piso_serializer #(.N(4), .LSB_FIRST(1'b1)) u_lsb (
        .clk       (clk),
        .rst       (rst),
        .din       (l_din),
        .din_valid (l_din_valid),
        .din_ready (l_din_ready),
        .so        (l_so),
        .so_valid  (l_so_valid),
        .done      (l_done)
    );

    always #5 clk = ~clk;

    // Downstream 4-bit serial shift register, si = so.
    always @(posedge clk or negedge rst) begin
        if (!rst) sr <= 4'b0000;
        else      sr <= {sr[2:0], so};
    end

    task automatic test_reset();
        #12;
        total++;
        if ({so, so_valid, done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_out: got so/vld/done=%b%b%b want 000", so, so_valid, done);
        end
        total++;
        if ({l_so, l_so_valid, l_done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_lsb_out: got so/vld/done=%b%b%b want 000", l_so, l_so_valid, l_done);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({din_ready, so_valid} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release: got rdy/vld=%b%b want 10", din_ready, so_valid);
        end
    endtask

    task automatic test_single();
        logic [W-1:0] exp;
`ifdef PISO_PARITY_EN
        exp = 5'b01100;
`else
        exp = 4'b0110;
`endif
        @(negedge clk);
        din = 4'b0110; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; din = 4'b0000;
        for (int i = 0; i < W + 4; i++) begin
            total++;
            if (i < W) begin
                if ({so, so_valid, done} !== {exp[W-1-i], 1'b1, (i == W-1)}) begin
                    bad++;
                    $display("FAIL single bit%0d: got so/vld/done=%b%b%b want %b1%b",
                             i, so, so_valid, done, exp[W-1-i], (i == W-1));
                end
            end else begin
                if ({so, so_valid, done} !== 3'b000) begin
                    bad++;
                    $display("FAIL single idle%0d: got so/vld/done=%b%b%b want 000", i, so, so_valid, done);
                end
            end
            if (i >= 4) begin
                total++;
                if (sr[3] !== exp[W-1-(i-4)]) begin
                    bad++;
                    $display("FAIL chain bit%0d: got %b want %b", i - 4, sr[3], exp[W-1-(i-4)]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] exp;
`ifdef PISO_PARITY_EN
        exp = 10'b10100_01010;
`else
        exp = 8'b1010_0101;
`endif
        @(negedge clk);
        din = 4'b1010; din_valid = 1'b1;
        @(negedge clk);
        din = 4'b0101;
        for (int i = 0; i < 2 * W; i++) begin
            total++;
            if ({so, so_valid, done, din_ready} !==
                {exp[2*W-1-i], 1'b1, (i == W-1 || i == 2*W-1), (i == W-1 || i == 2*W-1)}) begin
                bad++;
                $display("FAIL b2b bit%0d: got so/vld/done/rdy=%b%b%b%b want %b1%b%b", i,
                         so, so_valid, done, din_ready, exp[2*W-1-i],
                         (i == W-1 || i == 2*W-1), (i == W-1 || i == 2*W-1));
            end
            if (i == W) din_valid = 1'b0;
            @(negedge clk);
        end
        total++;
        if ({so, so_valid, done} !== 3'b000) begin
            bad++;
            $display("FAIL b2b idle: got so/vld/done=%b%b%b want 000", so, so_valid, done);
        end
    endtask

    task automatic test_hold_busy();
        logic [2*W-1:0] exp;
`ifdef PISO_PARITY_EN
        exp = 10'b00000_11110;
`else
        exp = 8'b0000_1111;
`endif
        @(negedge clk);
        din = 4'b0000; din_valid = 1'b1;
        @(negedge clk);
        din = 4'b1111;
        for (int i = 0; i < 2 * W; i++) begin
            total++;
            if ({so, so_valid, din_ready} !== {exp[2*W-1-i], 1'b1, (i == W-1 || i == 2*W-1)}) begin
                bad++;
                $display("FAIL hold bit%0d: got so/vld/rdy=%b%b%b want %b1%b", i,
                         so, so_valid, din_ready, exp[2*W-1-i], (i == W-1 || i == 2*W-1));
            end
            if (i == W) din_valid = 1'b0;
            @(negedge clk);
        end
        total++;
        if ({so_valid, din_ready} !== 2'b01) begin
            bad++;
            $display("FAIL hold idle: got vld/rdy=%b%b want 01", so_valid, din_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] exp;
`ifdef PISO_PARITY_EN
        exp = 5'b00110;
`else
        exp = 4'b0011;
`endif
        @(negedge clk);
        din = 4'b1001; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        total++;
        if ({so, so_valid} !== 2'b11) begin
            bad++;
            $display("FAIL rstmid bit0: got so/vld=%b%b want 11", so, so_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({so, so_valid, done} !== 3'b000) begin
            bad++;
            $display("FAIL rstmid out: got so/vld/done=%b%b%b want 000", so, so_valid, done);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({din_ready, so_valid} !== 2'b10) begin
            bad++;
            $display("FAIL rstmid release: got rdy/vld=%b%b want 10", din_ready, so_valid);
        end
        din = 4'b0011; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            total++;
            if ({so, so_valid, done} !== {exp[W-1-i], 1'b1, (i == W-1)}) begin
                bad++;
                $display("FAIL rstmid word bit%0d: got so/vld/done=%b%b%b want %b1%b",
                         i, so, so_valid, done, exp[W-1-i], (i == W-1));
            end
            @(negedge clk);
        end
        total++;
        if ({so, so_valid, done} !== 3'b000) begin
            bad++;
            $display("FAIL rstmid idle: got so/vld/done=%b%b%b want 000", so, so_valid, done);
        end
    endtask

    task automatic test_lsb_first();
        logic [W-1:0] exp;
`ifdef PISO_PARITY_EN
        exp = 5'b10001;
`else
        exp = 4'b1000;
`endif
        @(negedge clk);
        l_din = 4'b0001; l_din_valid = 1'b1;
        @(negedge clk);
        l_din_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            total++;
            if ({l_so, l_so_valid, l_done} !== {exp[W-1-i], 1'b1, (i == W-1)}) begin
                bad++;
                $display("FAIL lsb bit%0d: got so/vld/done=%b%b%b want %b1%b",
                         i, l_so, l_so_valid, l_done, exp[W-1-i], (i == W-1));
            end
            @(negedge clk);
        end
        total++;
        if ({l_so, l_so_valid, l_done, l_din_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL lsb idle: got so/vld/done/rdy=%b%b%b%b want 0001",
                     l_so, l_so_valid, l_done, l_din_ready);
        end
    endtask

    task automatic test_parity_word();
        logic [W-1:0] exp;
`ifdef PISO_PARITY_EN
        exp = 5'b01111;
`else
        exp = 4'b0111;
`endif
        @(negedge clk);
        din = 4'b0111; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            total++;
            if ({so, so_valid, done} !== {exp[W-1-i], 1'b1, (i == W-1)}) begin
                bad++;
                $display("FAIL parity bit%0d: got so/vld/done=%b%b%b want %b1%b",
                         i, so, so_valid, done, exp[W-1-i], (i == W-1));
            end
            @(negedge clk);
        end
        total++;
        if ({so, so_valid, done} !== 3'b000) begin
            bad++;
            $display("FAIL parity idle: got so/vld/done=%b%b%b want 000", so, so_valid, done);
        end
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b0;
        din         = 4'b0000;
        din_valid   = 1'b0;
        l_din       = 4'b0000;
        l_din_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_busy();
        test_reset_mid();
        test_lsb_first();
        test_parity_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
